wb_block_ram: RTL and testbench

Parametrised, pipelined Wishbone data memory for the `riscv` core's load/store port; the successor to the fixed `block_ram`. It adds configurable depth and read latency, RISC-V `funct3` byte/half/word access with sign or zero extension, and a write-protected low region for firmware. It also adds an optional post-reset zeroing sequencer and an error response for illegal accesses. It sits between `riscv` (`o_data_addr`/`o_data`/`o_wb_sel`/`o_wb_we`/`i_data`) and the simulation or FPGA top level.

---
 rtl/wb_block_ram.sv | 171 +++++++++++++++++
 tb/tb_wb_block_ram.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_block_ram.sv
// wb_block_ram: pipelined Wishbone data memory for the riscv load/store port.
// Byte/half/word access by funct3 with sign/zero extension, a write-protected
// low region, optional zeroing sweep after reset and error responses for
// illegal accesses. Responses appear LATENCY cycles after acceptance.
//
// state   | meaning
// S_RESET | reset held or just released; first clear write happens here
// S_INIT  | clearing words RO_WORDS..DEPTH-1, one per cycle
// S_READY | accepting requests
module wb_block_ram #(
  parameter int    DEPTH         = 1024,
  parameter int    LATENCY       = 1,
  parameter int    RO_WORDS      = 0,
  parameter int    ZERO_ON_RESET = 0,
  parameter string INIT_FILE     = ""
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [2:0]  i_wb_sel,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  output logic [31:0] o_wb_data,
  output logic        o_wb_stall,
  output logic        o_wb_ack,
  output logic        o_wb_err
);

  localparam int AW = $clog2(DEPTH);
  localparam bit DO_INIT = (ZERO_ON_RESET != 0) && (RO_WORDS < DEPTH);
  localparam logic [AW-1:0] CLR_START = AW'(RO_WORDS);
  localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH - 1);
  localparam logic [AW:0] RO_LIM = (AW + 1)'(RO_WORDS);

  typedef enum logic [1:0] {S_RESET, S_INIT, S_READY} state_t;

  state_t        state;
  logic [AW-1:0] clr_idx;
  logic [3:0][7:0] mem [DEPTH];

  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic          bad;
  logic          accept;
  logic          store_en;
  logic          clr_en;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [31:0]   word;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   resp_data;

  logic [LATENCY-1:0] ack_p;
  logic [LATENCY-1:0] err_p;
  logic [31:0]        data_p [LATENCY];

  assign widx     = i_addr[AW+1:2];
  assign lane     = i_addr[1:0];
  assign accept   = i_wb_stb && (state == S_READY) && !i_reset;
  assign store_en = accept && i_wb_we && !bad;
  assign clr_en   = DO_INIT && !i_reset && (state == S_RESET || state == S_INIT);

  assign o_wb_stall = (state != S_READY);
  assign o_wb_ack   = ack_p[LATENCY-1];
  assign o_wb_err   = err_p[LATENCY-1];
  assign o_wb_data  = data_p[LATENCY-1];

  // Legality of the current request.
  always_comb begin
    bad = 1'b0;
    if (i_wb_sel == 3'b011 || i_wb_sel[2:1] == 2'b11) bad = 1'b1;
    if (i_wb_sel[1:0] == 2'b01 && i_addr[0]) bad = 1'b1;
    if (i_wb_sel[1:0] == 2'b10 && i_addr[1:0] != 2'b00) bad = 1'b1;
    if (|(i_addr >> (AW + 2))) bad = 1'b1;
    if (i_wb_we && ({1'b0, widx} < RO_LIM)) bad = 1'b1;
  end

  // Byte enables and lane-replicated store data; unselected lanes untouched.
  always_comb begin
    be = 4'b1111;
    wd = i_data;
    case (i_wb_sel[1:0])
      2'b00: begin
        be = 4'b0001 << lane;
        wd = {4{i_data[7:0]}};
      end
      2'b01: begin
        be = i_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{i_data[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = i_data;
      end
    endcase
  end

  // Load lane selection and extension; stores and errors return zero.
  always_comb begin
    word      = mem[widx];
    byte_v    = word[lane*8 +: 8];
    half_v    = i_addr[1] ? word[31:16] : word[15:0];
    resp_data = 32'h0;
    if (!bad && !i_wb_we) begin
      case (i_wb_sel)
        3'b000:  resp_data = {{24{byte_v[7]}}, byte_v};
        3'b100:  resp_data = {24'h0, byte_v};
        3'b001:  resp_data = {{16{half_v[15]}}, half_v};
        3'b101:  resp_data = {16'h0, half_v};
        3'b010:  resp_data = word;
        default: resp_data = 32'h0;
      endcase
    end
  end

  // Array write port shared by the clear sweep and bus stores.
  always_ff @(posedge i_clk) begin
    if (clr_en) begin
      mem[clr_idx] <= '0;
    end else if (store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][b] <= wd[8*b +: 8];
      end
    end
  end

  // Sequencer: reset, clear sweep, then ready.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= S_RESET;
      clr_idx <= CLR_START;
    end else begin
      case (state)
        S_RESET: begin
          if (DO_INIT) begin
            clr_idx <= clr_idx + 1'b1;
            state   <= (clr_idx == CLR_LAST) ? S_READY : S_INIT;
          end else begin
            state <= S_READY;
          end
        end
        S_INIT: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == CLR_LAST) state <= S_READY;
        end
        default: state <= S_READY;
      endcase
    end
  end

  // Response pipeline; reset drops everything in flight.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ack_p <= '0;
      err_p <= '0;
      for (int i = 0; i < LATENCY; i++) data_p[i] <= 32'h0;
    end else begin
      ack_p[0]  <= accept && !bad;
      err_p[0]  <= accept && bad;
      data_p[0] <= accept ? resp_data : 32'h0;
      for (int i = 1; i < LATENCY; i++) begin
        ack_p[i]  <= ack_p[i-1];
        err_p[i]  <= err_p[i-1];
        data_p[i] <= data_p[i-1];
      end
    end
  end

endmodule

// File: tb/tb_wb_block_ram.sv
// Bench for wb_block_ram: three instances (latency 1, 3, 4) share one
// stimulus stream; every negedge each instance's outputs are compared with
// the expected response due in that cycle, or with all-zero when none is due.
module tb_wb_block_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stb, we;
  logic [2:0]  sel;
  logic [31:0] addr, wdata;
  logic [2:0]  stall, ack, err;
  logic [31:0] rdata [3];

  wb_block_ram #(.DEPTH(16), .LATENCY(1), .RO_WORDS(4), .ZERO_ON_RESET(1)) u_l1 (
    .i_clk(clk), .i_reset(rst), .i_wb_stb(stb), .i_wb_we(we), .i_wb_sel(sel),
    .i_addr(addr), .i_data(wdata), .o_wb_data(rdata[0]), .o_wb_stall(stall[0]),
    .o_wb_ack(ack[0]), .o_wb_err(err[0]));
  wb_block_ram #(.DEPTH(16), .LATENCY(3), .RO_WORDS(4), .ZERO_ON_RESET(1)) u_l3 (
    .i_clk(clk), .i_reset(rst), .i_wb_stb(stb), .i_wb_we(we), .i_wb_sel(sel),
    .i_addr(addr), .i_data(wdata), .o_wb_data(rdata[1]), .o_wb_stall(stall[1]),
    .o_wb_ack(ack[1]), .o_wb_err(err[1]));
  wb_block_ram #(.DEPTH(16), .LATENCY(4), .RO_WORDS(4), .ZERO_ON_RESET(1)) u_l4 (
    .i_clk(clk), .i_reset(rst), .i_wb_stb(stb), .i_wb_we(we), .i_wb_sel(sel),
    .i_addr(addr), .i_data(wdata), .o_wb_data(rdata[2]), .o_wb_stall(stall[2]),
    .o_wb_ack(ack[2]), .o_wb_err(err[2]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int lat(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  // expected responses, indexed in issue order
  int          exp_k   [256];
  logic        exp_e   [256];
  logic [31:0] exp_d   [256];
  logic [2:0]  exp_drop[256];
  int          n_req = 0;
  int          rd[3] = '{0, 0, 0};
  int          resp_cnt[3] = '{0, 0, 0};
  bit          mon_en = 1'b0;

  logic [31:0] mem_m [16];

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        if (ack[i] || err[i]) resp_cnt[i]++;
        while (rd[i] < n_req && exp_drop[rd[i]][i]) rd[i]++;
        if (rd[i] < n_req && exp_k[rd[i]] + lat(i) - 1 == cyc) begin
          chk($sformatf("resp L%0d #%0d", lat(i), rd[i]),
              64'({ack[i], err[i], rdata[i]}),
              64'({!exp_e[rd[i]], exp_e[rd[i]], exp_d[rd[i]]}));
          rd[i]++;
        end else begin
          chk($sformatf("idle L%0d", lat(i)), 64'({ack[i], err[i], rdata[i]}), 64'h0);
        end
      end
    end
  end

  // reference memory: applies legal stores, returns error flag and load data
  task automatic model(input logic w, input logic [2:0] s, input logic [31:0] a,
                       input logic [31:0] d, output logic e, output logic [31:0] x);
    int wi, ln;
    logic [7:0]  b;
    logic [15:0] h;
    wi = int'(a[5:2]);
    ln = int'(a[1:0]);
    case (s)
      3'b000, 3'b100: e = 1'b0;
      3'b001, 3'b101: e = a[0];
      3'b010:         e = (a[1:0] != 2'b00);
      default:        e = 1'b1;
    endcase
    if (a > 32'h3F) e = 1'b1;
    if (w && a < 32'h10) e = 1'b1;
    x = 32'h0;
    if (!e) begin
      if (w) begin
        case (s[1:0])
          2'b00:   mem_m[wi][8*ln +: 8] = d[7:0];
          2'b01:   mem_m[wi][8*ln +: 16] = d[15:0];
          default: mem_m[wi] = d;
        endcase
      end else begin
        b = mem_m[wi][8*ln +: 8];
        h = mem_m[wi][8*ln +: 16];
        case (s)
          3'b000:  x = {{24{b[7]}}, b};
          3'b100:  x = {24'h0, b};
          3'b001:  x = {{16{h[15]}}, h};
          3'b101:  x = {16'h0, h};
          default: x = mem_m[wi];
        endcase
      end
    end
  endtask

  // drive one request for one edge; stb stays high afterwards
  task automatic req(input logic w, input logic [2:0] s, input logic [31:0] a,
                     input logic [31:0] d, input logic e, input logic [31:0] x,
                     input bit use_model);
    logic        me;
    logic [31:0] mx;
    stb = 1'b1; we = w; sel = s; addr = a; wdata = d;
    model(w, s, a, d, me, mx);
    exp_k[n_req]    = cyc + 1;
    exp_e[n_req]    = use_model ? me : e;
    exp_d[n_req]    = use_model ? mx : x;
    exp_drop[n_req] = 3'b000;
    n_req++;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    stb = 1'b0; we = 1'b0; sel = 3'b000; addr = 32'h0; wdata = 32'h0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_req();
    logic [2:0]  s;
    logic [31:0] a;
    logic        w;
    int r, ln, wi;
    w  = 1'($urandom_range(0, 1));
    r  = int'($urandom_range(0, 15));
    case (r % 5)
      0:       s = 3'b000;
      1:       s = 3'b001;
      2:       s = 3'b010;
      3:       s = 3'b100;
      default: s = 3'b101;
    endcase
    if (r == 13) s = 3'b011;
    if (r == 14) s = 3'b110;
    if (r == 15) s = 3'b111;
    ln = int'($urandom_range(0, 3));
    wi = int'($urandom_range(4, 15));
    if ($urandom_range(0, 7) != 0) begin
      if (s[1:0] == 2'b01) ln = ln & 2;
      if (s[1:0] == 2'b10) ln = 0;
    end
    a = 32'(wi * 4 + ln);
    if ($urandom_range(0, 15) == 0) a = a + 32'h40;
    if (w && $urandom_range(0, 7) == 0) a = a & 32'hF;
    req(w, s, a, $urandom, 1'b0, 32'h0, 1'b1);
  endtask

  // count stall cycles after reset release; the sweep must take 12 cycles
  task automatic wait_ready(input string tag);
    int cnt[3];
    bit done[3];
    for (int i = 0; i < 3; i++) begin
      cnt[i]  = 0;
      done[i] = 1'b0;
    end
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!done[i]) begin
          if (stall[i]) cnt[i]++;
          else done[i] = 1'b1;
        end
      end
      if (done[0] && done[1] && done[2]) break;
    end
    for (int i = 0; i < 3; i++) chk($sformatf("%s L%0d", tag, lat(i)), 64'(cnt[i]), 64'd12);
  endtask

  int base[3];
  int e_edge;

  initial begin
    rst = 1'b1; stb = 1'b0; we = 1'b0; sel = 3'b000; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset stall L%0d", lat(i)), 64'(stall[i]), 64'd1);
      chk($sformatf("reset outputs L%0d", lat(i)), 64'({ack[i], err[i], rdata[i]}), 64'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int m = 4; m < 16; m++) mem_m[m] = 32'h0;
    wait_ready("init stall cycles");
    @(posedge clk); #1;
    mon_en = 1'b1;

    // functional directed vectors
    req(1'b0, 3'b010, 32'h20, 32'h0,        1'b0, 32'h00000000, 1'b0);
    req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h00000000, 1'b0);
    req(1'b0, 3'b000, 32'h13, 32'h0,        1'b0, 32'hFFFFFFDE, 1'b0);
    req(1'b0, 3'b100, 32'h13, 32'h0,        1'b0, 32'h000000DE, 1'b0);
    req(1'b0, 3'b001, 32'h12, 32'h0,        1'b0, 32'hFFFFDEAD, 1'b0);
    req(1'b0, 3'b101, 32'h12, 32'h0,        1'b0, 32'h0000DEAD, 1'b0);
    req(1'b1, 3'b000, 32'h11, 32'h55,       1'b0, 32'h00000000, 1'b0);
    req(1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'hDEAD55EF, 1'b0);
    // illegal accesses
    req(1'b0, 3'b010, 32'h02, 32'h0,        1'b1, 32'h0, 1'b0);
    req(1'b0, 3'b001, 32'h05, 32'h0,        1'b1, 32'h0, 1'b0);
    req(1'b0, 3'b011, 32'h10, 32'h0,        1'b1, 32'h0, 1'b0);
    req(1'b0, 3'b010, 32'h40, 32'h0,        1'b1, 32'h0, 1'b0);
    req(1'b1, 3'b010, 32'h04, 32'h12345678, 1'b1, 32'h0, 1'b0);
    req(1'b1, 3'b010, 32'h12, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0);
    req(1'b1, 3'b000, 32'h44, 32'hAA,       1'b1, 32'h0, 1'b0);
    req(1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'hDEAD55EF, 1'b0);
    // top word of the array
    req(1'b1, 3'b001, 32'h3E, 32'hBEEF,     1'b0, 32'h00000000, 1'b0);
    req(1'b0, 3'b010, 32'h3C, 32'h0,        1'b0, 32'hBEEF0000, 1'b0);
    req(1'b0, 3'b000, 32'h3F, 32'h0,        1'b0, 32'hFFFFFFBE, 1'b0);
    req(1'b0, 3'b101, 32'h3C, 32'h0,        1'b0, 32'h00000000, 1'b0);
    req(1'b0, 3'b001, 32'h3E, 32'h0,        1'b0, 32'hFFFFBEEF, 1'b0);
    idle(8);

    // reset with loads in flight
    req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEAD55EF, 1'b0);
    req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEAD55EF, 1'b0);
    req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEAD55EF, 1'b0);
    stb = 1'b0;
    rst = 1'b1;
    e_edge = cyc + 1;
    for (int j = 0; j < n_req; j++)
      for (int i = 0; i < 3; i++)
        if (exp_k[j] + lat(i) - 1 >= e_edge) exp_drop[j][i] = 1'b1;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) chk($sformatf("stall in reset L%0d", lat(i)), 64'(stall[i]), 64'd1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int m = 4; m < 16; m++) mem_m[m] = 32'h0;
    wait_ready("re-init stall cycles");
    @(posedge clk); #1;
    req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h00000000, 1'b0);
    req(1'b0, 3'b010, 32'h3C, 32'h0, 1'b0, 32'h00000000, 1'b0);
    idle(6);

    // continuous random stream against the reference model
    for (int i = 0; i < 3; i++) base[i] = resp_cnt[i];
    for (int t = 0; t < 64; t++) rand_req();
    idle(1);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk); #1;
      if (rd[0] == n_req && rd[1] == n_req && rd[2] == n_req) break;
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("drained L%0d", lat(i)), 64'(rd[i]), 64'(n_req));
      chk($sformatf("stream responses L%0d", lat(i)), 64'(resp_cnt[i] - base[i]), 64'd64);
    end
    idle(2);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
